// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32I core constants: data width, bubble encoding,
//               PC step and fetch state-machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_INC       = 32'd4;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t FETCH_BOOT = 2'd0;
   localparam fetch_state_t FETCH_RUN  = 2'd1;
   localparam fetch_state_t FETCH_HALT = 2'd2;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/if_fetch_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register; load, hold or insert a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic            bubble_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o,
   output logic            valid_o
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] instr_d;
   logic            valid_q;
   logic            valid_d;

   // Bubble wins over load so a flush can never leak a captured word.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (bubble_i) begin
         pc_d    = '0;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (load_i) begin
         pc_d    = pc_i;
         instr_d = instr_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : RV32I instruction fetch: PC, boot/run/halt control, IF/ID.
//               Optional macro IF_MISALIGN_CHECK_EN adds misalign_o and
//               word-aligns redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned     IMEM_BYTES = 256,
   parameter logic [XLEN-1:0] NOP_INSTR  = RV_NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic [XLEN-1:0] ifid_pc_o,
   output logic [XLEN-1:0] ifid_instr_o,
   output logic            ifid_valid_o,
   output logic            halted_o
`ifdef IF_MISALIGN_CHECK_EN
   ,
   output logic            misalign_o
`endif
);

   localparam logic [XLEN-1:0] LAST_PC = 32'(IMEM_BYTES - 4);

   fetch_state_t    state_q;
   fetch_state_t    state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic            halted_q;
   logic            halted_d;
   logic [XLEN-1:0] target_pc;
   logic            ifid_load;
   logic            ifid_bubble;

`ifdef IF_MISALIGN_CHECK_EN
   logic            misalign_q;
   logic            misalign_d;

   assign target_pc  = {redirect_pc_i[XLEN-1:2], 2'b00};
   assign misalign_d = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
   assign target_pc  = redirect_pc_i;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      case (state_q)
         FETCH_BOOT: begin
            ifid_bubble = 1'b1;
            state_d     = FETCH_RUN;
            if (redirect_i) begin
               pc_d = target_pc;
            end
         end
         FETCH_RUN: begin
            if (redirect_i) begin
               pc_d        = target_pc;
               ifid_bubble = 1'b1;
            end else if (stall_i) begin
               pc_d = pc_q;
            end else if (pc_q > LAST_PC) begin
               // Out-of-range word is dropped; PC parks at the faulting address.
               ifid_bubble = 1'b1;
               state_d     = FETCH_HALT;
            end else begin
               ifid_load = 1'b1;
               pc_d      = pc_q + PC_INC;
            end
         end
         FETCH_HALT: begin
            ifid_bubble = 1'b1;
            if (redirect_i) begin
               pc_d    = target_pc;
               state_d = FETCH_RUN;
            end
         end
         default: begin
            ifid_bubble = 1'b1;
            state_d     = FETCH_BOOT;
         end
      endcase
      halted_d = (state_d == FETCH_HALT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= FETCH_BOOT;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign misalign_o = misalign_q;
`endif

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk      (clk),
      .reset    (reset),
      .load_i   (ifid_load),
      .bubble_i (ifid_bubble),
      .pc_i     (pc_q),
      .instr_i  (imem_rdata),
      .pc_o     (ifid_pc_o),
      .instr_o  (ifid_instr_o),
      .valid_o  (ifid_valid_o)
   );

   assign imem_addr = pc_q;
   assign halted_o  = halted_q;

endmodule : if_fetch_stage
`default_nettype wire
